// File: rtl/segsel_pkg.sv
// segsel_pkg: shared segment codes, range bounds, FSM states and segment record
package segsel_pkg;
  localparam logic [1:0] EXPDOWN = 2'd1;
  localparam logic [1:0] EXPUP = 2'd2;
  localparam logic [1:0] UNIFORM = 2'd3;
  localparam logic signed [7:0] MIN_VAR = 8'sh80;
  localparam logic signed [7:0] MAX_VAR = 8'sh7f;
  typedef enum logic [2:0] {IDLE, BUILD, DRAW, SCAN0, SCAN1, SCAN2, DONE} state_t;
  typedef struct packed {
    logic [1:0] kind;
    logic signed [7:0] lo;
    logic signed [7:0] hi;
    logic [8:0] weight;
  } seg_t;
  function automatic seg_t mk_seg(input logic [1:0] kind, input logic signed [7:0] lo, input logic signed [7:0] hi, input logic [8:0] ew);
    seg_t s;
    s.kind = kind;
    s.lo = lo;
    s.hi = hi;
    s.weight = kind == UNIFORM ? {hi[7], hi} - {lo[7], lo} + 9'd1 : ew;
    return s;
  endfunction
endpackage

// File: rtl/lfsr16_step.sv
// lfsr16_step: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1 with seed load on reset
module lfsr16_step (
  input logic clk,
  input logic rst,
  input logic step,
  input logic [15:0] seed,
  output logic [15:0] next
);
  logic [15:0] value;
  assign next = {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  always_ff @(posedge clk)
    if (rst) value <= seed == 16'd0 ? 16'd1 : seed;
    else if (step) value <= next;
endmodule

// File: rtl/segment_draw_sequencer.sv
// segment_draw_sequencer: builds a constraint segment table and draws one weighted segment per request
module segment_draw_sequencer
  import segsel_pkg::*;
#(
  parameter logic [8:0] EXP_WEIGHT = 9'd2
) (
  input logic in_clock,
  input logic in_reset,
  input logic in_enable,
  input logic [15:0] in_seed,
  input logic in_valid,
  output logic in_ready,
  input logic signed [7:0] in_c_less_than,
  input logic signed [7:0] in_c_more_than,
  input logic [1:0] in_flag,
  output logic out_valid,
  input logic out_ready,
  output logic [1:0] out_type,
  output logic signed [7:0] out_from,
  output logic signed [7:0] out_to,
  output logic [8:0] out_weight,
  output logic [8:0] out_total,
  output logic out_error
);
  state_t state, nxt;
  logic signed [7:0] less, more, mid;
  logic [1:0] flag;
  logic [8:0] total, r, cum, cum_n;
  logic hit, err;
  logic [15:0] lfsr_next;
  seg_t s0, s1, s2, b0, b1, b2, cur, pick;
  lfsr16_step u_lfsr (
    .clk(in_clock),
    .rst(in_reset),
    .step(in_enable && state == DRAW),
    .seed(in_seed),
    .next(lfsr_next)
  );
  assign in_ready = state == IDLE;
  assign mid = 8'(({less[7], less} + {more[7], more}) >> 1);
  assign cur = state == SCAN0 ? s0 : state == SCAN1 ? s1 : s2;
  assign cum_n = cum + cur.weight;
  always_comb begin
    b0 = '0;
    b1 = '0;
    b2 = '0;
    if (flag == 2'd1) begin
      b0 = mk_seg(UNIFORM, MIN_VAR, less, EXP_WEIGHT);
      b1 = mk_seg(EXPDOWN, less, MAX_VAR, EXP_WEIGHT);
    end else if (flag == 2'd2 || (flag == 2'd3 && less >= more)) begin
      b0 = mk_seg(EXPUP, MIN_VAR, more, EXP_WEIGHT);
      b1 = mk_seg(UNIFORM, more, flag == 2'd3 ? less : MAX_VAR, EXP_WEIGHT);
      b2 = flag == 2'd3 ? mk_seg(EXPDOWN, less, MAX_VAR, EXP_WEIGHT) : '0;
    end else if (flag == 2'd3) begin
      b0 = mk_seg(EXPUP, MIN_VAR, mid, EXP_WEIGHT);
      b1 = mk_seg(EXPDOWN, mid, MAX_VAR, EXP_WEIGHT);
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid ? BUILD : IDLE;
      BUILD: nxt = flag == 2'd0 ? DONE : DRAW;
      DRAW: nxt = SCAN0;
      SCAN0: nxt = SCAN1;
      SCAN1: nxt = SCAN2;
      SCAN2: nxt = DONE;
      DONE: nxt = out_valid && out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge in_clock)
    if (in_reset) state <= IDLE;
    else if (in_enable) state <= nxt;
  always_ff @(posedge in_clock)
    if (in_reset) begin
      {less, more, flag} <= '0;
      {s0, s1, s2, pick} <= '0;
      {total, r, cum, hit, err} <= '0;
      {out_valid, out_type, out_from, out_to, out_weight, out_total, out_error} <= '0;
    end else if (in_enable) begin
      if (state == IDLE && in_valid) {less, more, flag} <= {in_c_less_than, in_c_more_than, in_flag};
      if (state == BUILD) begin
        {s0, s1, s2} <= {b0, b1, b2};
        pick <= '0;
        total <= b0.weight + b1.weight + b2.weight;
        {cum, hit, err} <= {9'd0, 1'b0, flag == 2'd0};
      end
      if (state == DRAW) r <= 9'(({9'd0, lfsr_next} * {16'd0, total}) >> 16);
      if (state inside {SCAN0, SCAN1, SCAN2}) begin
        cum <= cum_n;
        if (!hit && r < cum_n) {pick, hit} <= {cur, 1'b1};
      end
      if (state == DONE) begin
        if (!out_valid) {out_valid, out_type, out_from, out_to, out_weight, out_total, out_error} <= {1'b1, pick, total, err};
        else if (out_ready) out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_segment_draw_sequencer.sv
// tb_segment_draw_sequencer: table-driven and directed checks of segment_draw_sequencer
module tb_segment_draw_sequencer;
  localparam int ED = 1, EU = 2, UN = 3, NV = 12;
  typedef struct packed {
    logic rst;
    logic [15:0] seed;
    logic signed [7:0] less;
    logic signed [7:0] more;
    logic [1:0] flag;
    logic [8:0] total;
    logic [2:0][1:0] kind;
    logic [2:0][7:0] lo;
    logic [2:0][7:0] hi;
    logic [2:0][8:0] w;
  } vec_t;
  logic in_clock = 0, in_reset = 0, in_enable = 1, in_valid = 0, out_ready = 1;
  logic [15:0] in_seed = 0;
  logic signed [7:0] in_c_less_than = 0, in_c_more_than = 0;
  logic [1:0] in_flag = 0;
  logic in_ready, out_valid, out_error;
  logic [1:0] out_type;
  logic signed [7:0] out_from, out_to;
  logic [8:0] out_weight, out_total;
  int n_chk = 0, n_fail = 0, lat;
  vec_t tab [NV];
  segment_draw_sequencer dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_enable(in_enable),
    .in_seed(in_seed),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_c_less_than(in_c_less_than),
    .in_c_more_than(in_c_more_than),
    .in_flag(in_flag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_type(out_type),
    .out_from(out_from),
    .out_to(out_to),
    .out_weight(out_weight),
    .out_total(out_total),
    .out_error(out_error)
  );
  always #5 in_clock = ~in_clock;
  function automatic vec_t v(input logic r, input logic [15:0] s, input int l, m, f, t,
                             input int k0, a0, z0, w0, input int k1, a1, z1, w1, input int k2, a2, z2, w2);
    vec_t x;
    x.rst = r;
    x.seed = s;
    x.less = 8'(l);
    x.more = 8'(m);
    x.flag = 2'(f);
    x.total = 9'(t);
    x.kind = {2'(k2), 2'(k1), 2'(k0)};
    x.lo = {8'(a2), 8'(a1), 8'(a0)};
    x.hi = {8'(z2), 8'(z1), 8'(z0)};
    x.w = {9'(w2), 9'(w1), 9'(w0)};
    return x;
  endfunction
  function automatic logic [15:0] model_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset(input logic [15:0] s);
    @(negedge in_clock);
    in_reset = 1;
    in_seed = s;
    @(negedge in_clock);
    in_reset = 0;
  endtask
  task automatic request(input logic signed [7:0] l, input logic signed [7:0] m, input logic [1:0] f);
    @(negedge in_clock);
    in_valid = 1;
    in_c_less_than = l;
    in_c_more_than = m;
    in_flag = f;
    @(posedge in_clock);
    #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge in_clock);
      #1 lat++;
    end
  endtask
  task automatic check_out(input string p, input int t, input int a, input int z, input int w, input int tot, input int e);
    check({p, "_type"}, out_type, t);
    check({p, "_from"}, out_from, a);
    check({p, "_to"}, out_to, z);
    check({p, "_weight"}, out_weight, w);
    check({p, "_total"}, out_total, tot);
    check({p, "_error"}, out_error, e);
  endtask
  initial begin
    vec_t tv;
    logic [15:0] ml;
    int r, cum, k, seen;
    string p;
    tab[0] = v(1, 16'h0000, 0, 10, 2, 120, EU, -128, 10, 2, UN, 10, 127, 118, 0, 0, 0, 0);
    tab[1] = v(0, 16'h0000, 0, 10, 2, 120, EU, -128, 10, 2, UN, 10, 127, 118, 0, 0, 0, 0);
    tab[2] = v(1, 16'h4000, 0, 10, 2, 120, EU, -128, 10, 2, UN, 10, 127, 118, 0, 0, 0, 0);
    tab[3] = v(0, 16'h0000, 20, -20, 3, 45, EU, -128, -20, 2, UN, -20, 20, 41, ED, 20, 127, 2);
    tab[4] = v(1, 16'hFFFF, 20, -20, 3, 45, EU, -128, -20, 2, UN, -20, 20, 41, ED, 20, 127, 2);
    tab[5] = v(0, 16'h0000, -11, 0, 3, 4, EU, -128, -6, 2, ED, -6, 127, 2, 0, 0, 0, 0);
    tab[6] = v(0, 16'h0000, 50, 0, 1, 181, UN, -128, 50, 179, ED, 50, 127, 2, 0, 0, 0, 0);
    tab[7] = v(0, 16'h0000, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[8] = v(0, 16'h0000, 5, 5, 3, 5, EU, -128, 5, 2, UN, 5, 5, 1, ED, 5, 127, 2);
    tab[9] = v(0, 16'h0000, -128, 127, 3, 4, EU, -128, -1, 2, ED, -1, 127, 2, 0, 0, 0, 0);
    tab[10] = v(0, 16'h0000, 0, -128, 2, 258, EU, -128, -128, 2, UN, -128, 127, 256, 0, 0, 0, 0);
    tab[11] = v(0, 16'h0000, 127, 0, 1, 258, UN, -128, 127, 256, ED, 127, 127, 2, 0, 0, 0, 0);
    do_reset(16'h0000);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check_out("rst", 0, 0, 0, 0, 0, 0);
    out_ready = 0;
    request(8'sd3, 8'sd7, 2'd0);
    check("err_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge in_clock);
      #1;
      check("err_hold_valid", out_valid, 1);
      check("err_hold_ready", in_ready, 0);
      check_out("err_hold", 0, 0, 0, 0, 0, 1);
    end
    out_ready = 1;
    @(posedge in_clock);
    #1 check("err_release", out_valid, 0);
    ml = 16'h0001;
    for (int i = 0; i < NV; i++) begin
      tv = tab[i];
      p = $sformatf("v%0d", i);
      if (tv.rst) begin
        do_reset(tv.seed);
        ml = tv.seed == 16'd0 ? 16'd1 : tv.seed;
      end
      k = 3;
      if (tv.flag != 2'd0) begin
        ml = model_step(ml);
        r = (int'(ml) * int'(tv.total)) >> 16;
        cum = 0;
        for (int j = 0; j < 3; j++) begin
          cum += int'(tv.w[j]);
          if (k == 3 && r < cum) k = j;
        end
      end
      request(tv.less, tv.more, tv.flag);
      check({p, "_latency"}, lat, tv.flag == 2'd0 ? 2 : 6);
      if (k == 3) check_out(p, 0, 0, 0, 0, tv.total, tv.flag == 2'd0);
      else check_out(p, tv.kind[k], $signed(tv.lo[k]), $signed(tv.hi[k]), tv.w[k], tv.total, 0);
      @(posedge in_clock);
      #1;
      check({p, "_release"}, out_valid, 0);
      check({p, "_ready_back"}, in_ready, 1);
    end
    do_reset(16'h4000);
    @(negedge in_clock);
    in_valid = 1;
    in_c_less_than = 0;
    in_c_more_than = 10;
    in_flag = 2;
    @(posedge in_clock);
    #1 in_valid = 0;
    repeat (3) @(posedge in_clock);
    #1 in_enable = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge in_clock);
      #1 check("stall_valid", out_valid, 0);
    end
    in_enable = 1;
    lat = 6;
    while (!out_valid && lat < 30) begin
      @(posedge in_clock);
      #1 lat++;
    end
    check("stall_latency", lat, 9);
    check_out("stall", UN, 10, 127, 118, 120, 0);
    @(posedge in_clock);
    #1 check("stall_release", out_valid, 0);
    @(negedge in_clock);
    in_valid = 1;
    in_c_less_than = 20;
    in_c_more_than = -20;
    in_flag = 3;
    @(posedge in_clock);
    #1 in_valid = 0;
    repeat (3) @(posedge in_clock);
    #1;
    in_reset = 1;
    in_enable = 0;
    in_seed = 16'hFFFF;
    @(posedge in_clock);
    #1;
    in_reset = 0;
    in_enable = 1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    seen = 0;
    repeat (8) begin
      @(posedge in_clock);
      #1 seen |= int'(out_valid);
    end
    check("abort_quiet", seen, 0);
    request(8'sd20, -8'sd20, 2'd3);
    check("reseed_latency", lat, 6);
    check_out("reseed", ED, 20, 127, 2, 45, 0);
    @(posedge in_clock);
    #1 check("reseed_release", out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/segment_draw_sequencer.md
Name: segment_draw_sequencer

Overview:
- Sequences one weighted segment draw per request for the MCMC probabilistic-search path.
- Accepts a variable's constraint bounds and flag through a valid/ready handshake and builds the segment table (EXPUP / UNIFORM / EXPDOWN).
- Draws a segment index from an internal LFSR, weighted by segment weights, then returns the chosen segment through a valid/ready handshake.
- Sits between the variable scheduler and the in-segment sampler.

Parameters:
- EXP_WEIGHT, 2, weight assigned to every exponential segment (unsigned, 9 bit).
- MIN_VAR, -128, lower bound of the variable range.
- MAX_VAR, 127, upper bound of the variable range.

Ports:
- in_clock  input  1  system clock
- in_reset  input  1  synchronous active-high reset; also loads the seed
- in_enable  input  1  global stall; 0 freezes FSM, LFSR and all registers
- in_seed  input  16  LFSR seed, sampled while in_reset=1
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready & in_enable
- in_c_less_than  input  8 signed  upper constraint bound
- in_c_more_than  input  8 signed  lower constraint bound
- in_flag  input  2  1=less-than only, 2=more-than only, 3=both, 0=invalid
- out_valid  output  1  result valid
- out_ready  input  1  consumer ready
- out_type  output  2  chosen segment type: 1=EXPDOWN, 2=EXPUP, 3=UNIFORM
- out_from  output  8 signed  segment start
- out_to  output  8 signed  segment end
- out_weight  output  9  chosen segment weight
- out_total  output  9  sum of all segment weights
- out_error  output  1  request had flag 0; segment fields are 0

Behaviour:
- Clock and reset are decided: single clock in_clock; in_reset is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_error=0, all data outputs 0, FSM=IDLE.
- LFSR loads in_seed on reset; seed 0 is replaced by 16'h0001.
- Reset mid-operation aborts the request with no output.
- FSM states: IDLE -> BUILD -> DRAW -> SCAN0 -> SCAN1 -> SCAN2 -> DONE -> IDLE.
  - IDLE: in_ready=1. On accept, capture the bounds and flag; go to BUILD.
  - BUILD: fill segment registers seg0..seg2 (type, from, to, weight). Unused segments get weight 0.
  - flag 2: seg0 EXPUP [MIN_VAR, more]; seg1 UNIFORM [more, MAX_VAR].
  - flag 1: seg0 UNIFORM [MIN_VAR, less]; seg1 EXPDOWN [less, MAX_VAR].
  - flag 3 with less >= more: seg0 EXPUP [MIN_VAR, more]; seg1 UNIFORM [more, less]; seg2 EXPDOWN [less, MAX_VAR].
  - flag 3 with less < more: mid = (sext9(less) + sext9(more)) >>> 1 (floor). seg0 EXPUP [MIN_VAR, mid]; seg1 EXPDOWN [mid, MAX_VAR].
  - flag 0: set out_error=1 and go directly to DONE.
- Weights: UNIFORM weight = to - from + 1, computed at 9 bits (range 1..256). EXPUP/EXPDOWN weight = EXP_WEIGHT. out_total = sum of the three weights, 9 bit (max 260, no overflow).
- DRAW: LFSR steps once (x^16+x^14+x^13+x^11+1, shift left, feedback into bit0).
  - r = (lfsr_new * total) >> 16, a 25-bit product, giving r in [0, total-1].
- SCAN0..2: one segment compared per cycle against a running cumulative weight.
  - The first k with r < cum_k latches as chosen.
  - Later SCAN cycles do not override an earlier hit.
  - Fixed 3 SCAN cycles, so latency is constant.
- DONE: out_valid=1 and outputs are held stable until out_ready=1. Then out_valid drops and the FSM returns to IDLE.
  - in_ready=0 in every state except IDLE.
- Latency: accept edge E0 -> out_valid visible after edge E6 (6 cycles) with out_ready held high. For flag 0 it is visible after E2.
- Throughput: the earliest next accept is the cycle after the out handshake.
- in_enable=0 in any state: no state, LFSR or output change; handshakes are not honoured.
- Simultaneous in_reset and in_enable=0: reset wins.

Decomposition:
- Shared package segsel_pkg holds:
  - type codes EXPDOWN=1, EXPUP=2, UNIFORM=3;
  - MIN_VAR, MAX_VAR;
  - the FSM state enum;
  - the segment record typedef (type, from, to, weight).
- One natural sub-module: lfsr16_step (combinational next-state plus a seed-load register), reused by the in-segment sampler.

Test Plan:
- Reset with in_seed=0 -> LFSR=0001, in_ready=1, out_valid=0. First DRAW yields lfsr_new=0002.
- flag=2, more=10 -> total=120.
  - r<2 -> EXPUP [-128,10] w2.
  - else -> UNIFORM [10,127] w118.
  - Bench LFSR model must match every draw; out_valid exactly 6 cycles after accept.
- flag=3, less=20, more=-20 -> segments EXPUP [-128,-20] w2, UNIFORM [-20,20] w41, EXPDOWN [20,127] w2; total=45.
  - Seed chosen so r=44 -> EXPDOWN.
- flag=3, less=-11, more=0 -> mid=-6; EXPUP [-128,-6], EXPDOWN [-6,127]; total=4.
- flag=0 -> out_error=1, out_total=0, out_valid after 2 cycles. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Mid-SCAN1 actions:
  - in_enable=0 for 3 cycles -> latency extends by 3, result unchanged.
  - in_reset pulse -> FSM IDLE, out_valid stays 0, LFSR reloads seed.
